mem_access_stage: RTL

//  MEM-stage data-memory access unit between the EX/MEM register and the MEM/WB register.
//  - Turns the EX/MEM load/store controls into a req/ack data-memory transaction with byte enables.
//  - Aligns and sign/zero-extends load data and drives Mem_ReadData into MEM/WB.
//  - Stalls the pipeline while memory is slow; detects misalignment and bus timeout.

---
 rtl/mem_access_stage_pkg.sv | 27 ++
 rtl/mem_access_stage_load_align.sv | 27 ++
 rtl/mem_access_stage.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/mem_access_stage_pkg.sv
// Shared size codes, FSM state encoding and alignment rule for the MEM-stage access unit.
// Pure declarations; no logic, no latency, no flow control.
package mem_access_stage_pkg;

   localparam logic [1:0] SIZE_B = 2'b00;
   localparam logic [1:0] SIZE_H = 2'b01;
   localparam logic [1:0] SIZE_W = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_HELD = 2'd2
   } mem_state_t;

   // The reserved size code is reported as misaligned so it never reaches the bus.
   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] a);
      logic m;
      case (size)
         SIZE_B:  m = 1'b0;
         SIZE_H:  m = a[0];
         SIZE_W:  m = (a != 2'b00);
         default: m = 1'b1;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/mem_access_stage_load_align.sv
// Load lane select plus sign/zero extension, combinational (0 cycles).
// No flow control; used for both the live read path and the hold-register input.
module mem_load_align
   import mem_access_stage_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  addr_lo,
   input  logic [1:0]  size,
   input  logic        is_signed,
   output logic [31:0] data
);

   logic [31:0] shifted;

   assign shifted = rdata >> {addr_lo, 3'b000};

   always_comb begin
      data = '0;
      case (size)
         SIZE_B:  data = {{24{is_signed & shifted[7]}}, shifted[7:0]};
         SIZE_H:  data = {{16{is_signed & shifted[15]}}, shifted[15:0]};
         SIZE_W:  data = rdata;
         default: data = '0;
      endcase
   end

endmodule

// File: rtl/mem_access_stage.sv
// MEM-stage data-memory access: req/ack bus, load alignment, stall, misalign and timeout.
// Zero-wait on same-cycle ack; stalls the pipe until ack, holds read data while pipe_hold is high.
module mem_access_stage
   import mem_access_stage_pkg::*;
#(
   parameter int TIMEOUT = 255,
   parameter int CNT_W   = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        Ex_MemRead,
   input  logic        Ex_MemWrite,
   input  logic [1:0]  Ex_MemSize,
   input  logic        Ex_MemSigned,
   input  logic [31:0] Ex_ALUout,
   input  logic [31:0] Ex_WriteData,
   input  logic        pipe_hold,
   output logic        dm_req,
   output logic        dm_we,
   output logic [31:0] dm_addr,
   output logic [3:0]  dm_be,
   output logic [31:0] dm_wdata,
   input  logic        dm_ack,
   input  logic [31:0] dm_rdata,
   output logic [31:0] Mem_ReadData,
   output logic        Mem_stall,
   output logic        Mem_misalign,
   output logic        Mem_buserr
);

   localparam logic [CNT_W-1:0] TO_V = CNT_W'(TIMEOUT);

   mem_state_t       state;
   logic [CNT_W-1:0] cnt;
   logic [31:0]      hold_q;

   logic        rd_wr, mis, acc, timeout;
   logic [31:0] ld_data, live_rd;
   logic [3:0]  be;
   logic [31:0] wdata;
   logic        req_c, stall_c, buserr_c;
   logic [31:0] rdata_c;

   assign rd_wr   = Ex_MemRead | Ex_MemWrite;
   assign mis     = is_misaligned(Ex_MemSize, Ex_ALUout[1:0]);
   assign acc     = rd_wr & ~mis;
   assign timeout = (TIMEOUT != 0) && (state == ST_WAIT) && !dm_ack && (cnt == TO_V);

   mem_load_align u_align (
      .rdata     (dm_rdata),
      .addr_lo   (Ex_ALUout[1:0]),
      .size      (Ex_MemSize),
      .is_signed (Ex_MemSigned),
      .data      (ld_data)
   );

   assign live_rd = (Ex_MemRead & ~mis) ? ld_data : 32'd0;

   always_comb begin
      be    = 4'b0000;
      wdata = Ex_WriteData;
      case (Ex_MemSize)
         SIZE_B: begin
            be    = 4'b0001 << Ex_ALUout[1:0];
            wdata = {4{Ex_WriteData[7:0]}};
         end
         SIZE_H: begin
            be    = 4'b0011 << Ex_ALUout[1:0];
            wdata = {2{Ex_WriteData[15:0]}};
         end
         SIZE_W:  be = 4'b1111;
         default: be = 4'b0000;
      endcase
   end

   always_comb begin
      req_c    = 1'b0;
      stall_c  = pipe_hold;
      buserr_c = 1'b0;
      rdata_c  = 32'd0;
      case (state)
         ST_IDLE: begin
            req_c = acc;
            if (acc) begin
               if (dm_ack) rdata_c = live_rd;
               else        stall_c = 1'b1;
            end
         end
         ST_WAIT: begin
            if (timeout) begin
               buserr_c = 1'b1;
            end else begin
               req_c = 1'b1;
               if (dm_ack) rdata_c = live_rd;
               else        stall_c = 1'b1;
            end
         end
         ST_HELD: rdata_c = hold_q;
         default: rdata_c = 32'd0;
      endcase
   end

   // Gating with reset makes an abandoned request drop the moment reset asserts.
   assign dm_req       = reset & req_c;
   assign dm_we        = dm_req & Ex_MemWrite;
   assign dm_addr      = dm_req ? {Ex_ALUout[31:2], 2'b00} : 32'd0;
   assign dm_be        = dm_req ? be : 4'b0000;
   assign dm_wdata     = dm_req ? wdata : 32'd0;
   assign Mem_ReadData = reset ? rdata_c : 32'd0;
   assign Mem_stall    = reset & stall_c;
   assign Mem_misalign = reset & rd_wr & mis;
   assign Mem_buserr   = reset & buserr_c;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state  <= ST_IDLE;
         cnt    <= '0;
         hold_q <= 32'd0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (acc) begin
                  if (!dm_ack) begin
                     state <= ST_WAIT;
                     cnt   <= CNT_W'(1);
                  end else if (pipe_hold) begin
                     hold_q <= live_rd;
                     state  <= ST_HELD;
                  end
               end
            end
            ST_WAIT: begin
               if (dm_ack) begin
                  if (pipe_hold) begin
                     hold_q <= live_rd;
                     state  <= ST_HELD;
                  end else begin
                     state <= ST_IDLE;
                  end
               end else if (timeout) begin
                  state <= ST_IDLE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            ST_HELD: begin
               if (!pipe_hold) state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
